fpu_round_pack: RTL and testbench

- Pipelined round-and-pack stage directly downstream of unit_normalize in the FP add/sub datapath.
- Consumes normalized {exp, 28-bit mant, ov/un flags} plus sign and NaN indication, rounds round-to-nearest-even by default, and packs the result into IEEE-754 binary32.
- Valid/ready handshake, 2-stage pipeline, sticky exception-flag accumulator.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_round_inc.sv | 26 ++
 rtl/fpu_round_pack.sv | 159 +++++++++++++++
 tb/tb_fpu_round_pack.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and types for the FP add/sub round-and-pack stage.
package fpu_pkg;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [31:0] QNAN_CANON     = 32'h7FC00000;
  localparam logic [7:0]  EXP_MAX        = 8'hFF;
  localparam logic [30:0] MAX_FINITE_MAG = 31'h7F7FFFFF;

  // Mantissa layout from unit_normalize: carry, hidden, 23-bit fraction, G, R, S
  localparam int MANT_W   = 28;
  localparam int M_CARRY  = 27;
  localparam int M_HIDDEN = 26;
  localparam int M_LSB    = 3;
  localparam int M_G      = 2;
  localparam int M_R      = 1;
  localparam int M_S      = 0;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

endpackage

// File: rtl/fpu_round_inc.sv
// Rounding increment decision for one mantissa; encodings 5-7 fall back to RNE.
module fpu_round_inc
  import fpu_pkg::*;
(
  input  logic lsb,
  input  logic g,
  input  logic r,
  input  logic s,
  input  logic sign,
  input  rm_e  rm,
  output logic inc,
  output logic inexact
);

  always_comb begin
    inexact = g | r | s;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = inexact & sign;
      RM_RUP:  inc = inexact & ~sign;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
  end

endmodule

// File: rtl/fpu_round_pack.sv
// Two-stage round-and-pack to IEEE-754 binary32 with valid/ready and sticky flags.
// Define ROUND_MODES_EN to add the i_rm port and directed rounding modes.
module fpu_round_pack
  import fpu_pkg::*;
#(
  parameter bit FLUSH_UF = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sign,
  input  logic              i_nan,
  input  logic [7:0]        i_exp,
  input  logic [MANT_W-1:0] i_mant,
  input  logic              i_ov_fl,
  input  logic              i_un_fl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_result,
  output logic [4:0]        o_flags,
`ifdef ROUND_MODES_EN
  input  logic [2:0]        i_rm,
`endif
  input  logic              i_fflags_clr,
  output logic [4:0]        o_fflags
);

  logic              s1_v, s2_v, s2_ready;
  logic              s1_sign, s1_nan, s1_ov, s1_un;
  logic [7:0]        s1_exp;
  logic [MANT_W-1:0] s1_mant;
  rm_e               rm_cur;

  assign s2_ready = ~s2_v | i_ready;
  assign o_ready  = ~s1_v | s2_ready;
  assign o_valid  = s2_v;

`ifdef ROUND_MODES_EN
  logic [2:0] s1_rm;
  assign rm_cur = rm_e'(s1_rm);
`else
  assign rm_cur = RM_RNE;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_v <= 1'b0;
    end else if (o_ready) begin
      s1_v <= i_valid;
      if (i_valid) begin
        s1_sign <= i_sign;
        s1_nan  <= i_nan;
        s1_exp  <= i_exp;
        s1_mant <= i_mant;
        s1_ov   <= i_ov_fl;
        s1_un   <= i_un_fl;
`ifdef ROUND_MODES_EN
        s1_rm   <= i_rm;
`endif
      end
    end
  end

  // A set carry bit means the value is one binade high; fold the lost bit into sticky.
  logic [MANT_W-1:0] m_fix;
  logic [8:0]        e_fix;

  always_comb begin
    m_fix = s1_mant;
    e_fix = {1'b0, s1_exp};
    if (s1_mant[M_CARRY]) begin
      m_fix      = {1'b0, s1_mant[MANT_W-1:1]};
      m_fix[M_S] = s1_mant[1] | s1_mant[0];
      e_fix      = e_fix + 9'd1;
    end
  end

  logic inc, inexact;

  fpu_round_inc u_round_inc (
    .lsb     (m_fix[M_LSB]),
    .g       (m_fix[M_G]),
    .r       (m_fix[M_R]),
    .s       (m_fix[M_S]),
    .sign    (s1_sign),
    .rm      (rm_cur),
    .inc     (inc),
    .inexact (inexact)
  );

  logic [24:0] sum;
  logic [8:0]  e_rnd;
  logic [22:0] frac;
  logic [31:0] ovf_res, res;
  logic        zero_sign;
  logic [4:0]  flg;

  assign sum   = {1'b0, m_fix[M_HIDDEN:M_LSB]} + {24'd0, inc};
  assign e_rnd = e_fix + {8'd0, sum[24]};
  assign frac  = sum[24] ? 23'd0 : sum[22:0];

`ifdef ROUND_MODES_EN
  logic to_max;
  assign to_max    = (rm_cur == RM_RTZ) || (rm_cur == RM_RDN && !s1_sign) ||
                     (rm_cur == RM_RUP && s1_sign);
  assign ovf_res   = to_max ? {s1_sign, MAX_FINITE_MAG} : {s1_sign, EXP_MAX, 23'd0};
  assign zero_sign = (rm_cur == RM_RDN);
`else
  assign ovf_res   = {s1_sign, EXP_MAX, 23'd0};
  assign zero_sign = 1'b0;
`endif

  always_comb begin
    res         = {s1_sign, e_rnd[7:0], frac};
    flg         = '0;
    flg[FLG_NX] = inexact;
    flg[FLG_DZ] = 1'b0;
    if (s1_nan) begin
      res         = QNAN_CANON;
      flg         = '0;
      flg[FLG_NV] = 1'b1;
    end else if (s1_ov || e_rnd >= {1'b0, EXP_MAX}) begin
      res         = ovf_res;
      flg         = '0;
      flg[FLG_OF] = 1'b1;
      flg[FLG_NX] = 1'b1;
    end else if (FLUSH_UF && (s1_un || e_rnd == 9'd0)) begin
      flg = '0;
      if (s1_un && s1_mant == '0) begin
        res = {zero_sign, 31'd0};
      end else begin
        res         = {s1_sign, 31'd0};
        flg[FLG_UF] = 1'b1;
        flg[FLG_NX] = 1'b1;
      end
    end
  end

  // Clear and a same-cycle handshake combine so the departing beat's flags are kept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_v     <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
      o_fflags <= '0;
    end else begin
      if (s2_ready) begin
        s2_v <= s1_v;
        if (s1_v) begin
          o_result <= res;
          o_flags  <= flg;
        end
      end
      o_fflags <= (i_fflags_clr ? 5'd0 : o_fflags) | ((s2_v && i_ready) ? o_flags : 5'd0);
    end
  end

endmodule

// File: tb/tb_fpu_round_pack.sv
// Scoreboard bench for fpu_round_pack: directed vectors, backpressure, reset, sticky flags, random stream.
module tb_fpu_round_pack;

  typedef struct packed {
    logic        sign;
    logic        nan;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic        ov;
    logic        un;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, o_ready, i_sign, i_nan, i_ov_fl, i_un_fl;
  logic [7:0]  i_exp;
  logic [27:0] i_mant;
  logic        o_valid, i_ready, i_fflags_clr;
  logic [31:0] o_result;
  logic [4:0]  o_flags, o_fflags;

  int          assert_count = 0;
  int          fail_count = 0;
  logic [36:0] sb[$];
  logic [36:0] next_exp;
  logic [4:0]  exp_ff = 5'd0;

  always #5 i_clk = ~i_clk;

  fpu_round_pack dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_sign       (i_sign),
    .i_nan        (i_nan),
    .i_exp        (i_exp),
    .i_mant       (i_mant),
    .i_ov_fl      (i_ov_fl),
    .i_un_fl      (i_un_fl),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_flags      (o_flags),
`ifdef ROUND_MODES_EN
    .i_rm         (3'd0),
`endif
    .i_fflags_clr (i_fflags_clr),
    .o_fflags     (o_fflags)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert_count++;
    if (obs !== expv) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference RNE round-and-pack, written with integer exponent arithmetic.
  function automatic logic [36:0] model(input beat_t b);
    int          ex;
    logic [27:0] mm;
    logic        g, r, s, lsb, inc, nx;
    logic [24:0] sm;
    logic [22:0] fr;
    if (b.nan) return {32'h7FC00000, 5'h10};
    ex = int'(b.exp);
    mm = b.mant;
    if (mm[27]) begin
      mm = (mm >> 1) | {27'd0, b.mant[0]};
      ex = ex + 1;
    end
    lsb = mm[3]; g = mm[2]; r = mm[1]; s = mm[0];
    inc = g && (r || s || lsb);
    nx  = g | r | s;
    sm  = {1'b0, mm[26:3]} + {24'd0, inc};
    if (sm[24]) begin
      ex = ex + 1;
      fr = 23'd0;
    end else begin
      fr = sm[22:0];
    end
    if (b.ov || ex >= 255) return {b.sign, 8'hFF, 23'd0, 5'h05};
    if (b.un || ex == 0) begin
      if (b.un && b.mant == 28'd0) return {32'd0, 5'h00};
      return {b.sign, 31'd0, 5'h03};
    end
    return {b.sign, ex[7:0], fr, 4'd0, nx};
  endfunction

  function automatic beat_t mk(input logic sg, input logic nn, input logic [7:0] e,
                               input logic [27:0] m, input logic ov, input logic un);
    beat_t b;
    b.sign = sg; b.nan = nn; b.exp = e; b.mant = m; b.ov = ov; b.un = un;
    return b;
  endfunction

  // One clock: settle, score any handshake, then step to the next falling edge.
  task automatic tick(output bit accepted, output bit hs);
    logic [36:0] ev;
    #1;
    accepted = 1'b0;
    hs = 1'b0;
    ev = '0;
    if (i_rst_n) begin
      if (o_valid && i_ready) begin
        hs = 1'b1;
        checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          ev = sb.pop_front();
          checkOutput("result", o_result, ev[36:5]);
          checkOutput("flags", {27'd0, o_flags}, {27'd0, ev[4:0]});
        end
      end
      exp_ff = (i_fflags_clr ? 5'd0 : exp_ff) | (hs ? ev[4:0] : 5'd0);
      if (i_valid && o_ready) begin
        sb.push_back(next_exp);
        accepted = 1'b1;
      end
    end
    @(posedge i_clk);
    if (!i_rst_n) begin
      sb.delete();
      exp_ff = 5'd0;
    end
    @(negedge i_clk);
  endtask

  task automatic present(input beat_t b, input logic [36:0] e);
    i_sign = b.sign; i_nan = b.nan; i_exp = b.exp; i_mant = b.mant;
    i_ov_fl = b.ov; i_un_fl = b.un;
    next_exp = e;
    i_valid = 1'b1;
  endtask

  task automatic applyStimulus(input beat_t b, input logic [36:0] e);
    bit acc, hs;
    present(b, e);
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) tick(acc, hs);
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit acc, hs;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick(acc, hs);
    checkOutput("drain_left", 32'(sb.size()), 32'd0);
    tick(acc, hs);
    checkOutput("fflags", {27'd0, o_fflags}, {27'd0, exp_ff});
  endtask

  beat_t       dir_b[13];
  logic [36:0] dir_e[13];

  initial begin
    bit acc, hs;
    beat_t rb;

    dir_b[0]  = mk(0, 0, 8'h7F, 28'h4000000, 0, 0); dir_e[0]  = {32'h3F800000, 5'h00};
    dir_b[1]  = mk(0, 0, 8'h7F, 28'h4000004, 0, 0); dir_e[1]  = {32'h3F800000, 5'h01};
    dir_b[2]  = mk(0, 0, 8'h7F, 28'h400000C, 0, 0); dir_e[2]  = {32'h3F800002, 5'h01};
    dir_b[3]  = mk(0, 0, 8'h7F, 28'h7FFFFFC, 0, 0); dir_e[3]  = {32'h40000000, 5'h01};
    dir_b[4]  = mk(0, 0, 8'hFE, 28'h7FFFFFC, 0, 0); dir_e[4]  = {32'h7F800000, 5'h05};
    dir_b[5]  = mk(0, 1, 8'h12, 28'h4000000, 0, 0); dir_e[5]  = {32'h7FC00000, 5'h10};
    dir_b[6]  = mk(1, 0, 8'h00, 28'h0000000, 0, 1); dir_e[6]  = {32'h00000000, 5'h00};
    dir_b[7]  = mk(1, 0, 8'h01, 28'h4000000, 0, 1); dir_e[7]  = {32'h80000000, 5'h03};
    dir_b[8]  = mk(1, 0, 8'h80, 28'h4000000, 1, 0); dir_e[8]  = {32'hFF800000, 5'h05};
    dir_b[9]  = mk(0, 0, 8'h7F, 28'h8000000, 0, 0); dir_e[9]  = {32'h40000000, 5'h00};
    dir_b[10] = mk(0, 0, 8'h00, 28'h4000000, 0, 0); dir_e[10] = {32'h00000000, 5'h03};
    dir_b[11] = mk(0, 0, 8'h7F, 28'h8000002, 0, 0); dir_e[11] = {32'h40000000, 5'h01};
    dir_b[12] = mk(0, 0, 8'hFE, 28'h8000000, 0, 0); dir_e[12] = {32'h7F800000, 5'h05};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_fflags_clr = 1'b0;
    i_sign = 1'b0; i_nan = 1'b0; i_exp = 8'd0; i_mant = 28'd0;
    i_ov_fl = 1'b0; i_un_fl = 1'b0; next_exp = '0;
    tick(acc, hs);
    tick(acc, hs);
    i_rst_n = 1'b1;
    #1;
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("rst_result", o_result, 32'd0);
    checkOutput("rst_flags", {27'd0, o_flags}, 32'd0);
    checkOutput("rst_fflags", {27'd0, o_fflags}, 32'd0);

    // Latency: valid appears after the second rising edge following acceptance
    applyStimulus(dir_b[0], dir_e[0]);
    i_valid = 1'b0;
    checkOutput("lat_c1", {31'd0, o_valid}, 32'd0);
    tick(acc, hs);
    checkOutput("lat_c2", {31'd0, o_valid}, 32'd1);
    drain();

    for (int k = 0; k < 13; k++) applyStimulus(dir_b[k], dir_e[k]);
    drain();

    // Backpressure: tie, NaN, overflow offered with downstream stalled
    i_fflags_clr = 1'b1;
    tick(acc, hs);
    i_fflags_clr = 1'b0;
    i_ready = 1'b0;
    applyStimulus(dir_b[1], dir_e[1]);
    applyStimulus(dir_b[5], dir_e[5]);
    present(dir_b[4], dir_e[4]);
    #1;
    checkOutput("bp_ready_low", {31'd0, o_ready}, 32'd0);
    for (int n = 0; n < 3; n++) begin
      tick(acc, hs);
      checkOutput("bp_no_accept", {31'd0, acc}, 32'd0);
      checkOutput("bp_hold_result", o_result, 32'h3F800000);
      checkOutput("bp_hold_flags", {27'd0, o_flags}, 32'h01);
    end
    i_ready = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) tick(acc, hs);
    if (!acc) checkOutput("bp_accept_timeout", 32'd0, 32'd1);
    drain();
    checkOutput("bp_fflags_or", {27'd0, o_fflags}, 32'h15);

    // Reset with both stages occupied
    i_ready = 1'b0;
    applyStimulus(dir_b[2], dir_e[2]);
    applyStimulus(dir_b[3], dir_e[3]);
    i_valid = 1'b0;
    #1;
    checkOutput("full_ready_low", {31'd0, o_ready}, 32'd0);
    i_rst_n = 1'b0;
    tick(acc, hs);
    i_rst_n = 1'b1;
    #1;
    checkOutput("rst2_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst2_fflags", {27'd0, o_fflags}, 32'd0);
    checkOutput("rst2_ready", {31'd0, o_ready}, 32'd1);
    i_ready = 1'b1;
    for (int n = 0; n < 3; n++) tick(acc, hs);
    checkOutput("rst2_no_ghost", {31'd0, o_valid}, 32'd0);

    // Sticky clear coinciding with an overflow handshake
    applyStimulus(dir_b[5], dir_e[5]);
    drain();
    checkOutput("nv_sticky", {27'd0, o_fflags}, 32'h10);
    applyStimulus(dir_b[8], dir_e[8]);
    i_valid = 1'b0;
    hs = 1'b0;
    for (int n = 0; n < 10 && !hs; n++) begin
      i_fflags_clr = o_valid;
      tick(acc, hs);
    end
    i_fflags_clr = 1'b0;
    checkOutput("clr_hs_seen", {31'd0, hs}, 32'd1);
    checkOutput("clr_hs_fflags", {27'd0, o_fflags}, 32'h05);

    // Random stream with random downstream stalls
    for (int k = 0; k < 60; k++) begin
      rb.sign = 1'($urandom_range(0, 1));
      rb.nan  = ($urandom_range(0, 15) == 0);
      rb.ov   = ($urandom_range(0, 15) == 0);
      rb.un   = ($urandom_range(0, 9) == 0);
      rb.exp  = 8'($urandom_range(0, 255));
      rb.mant = 28'($urandom) | 28'h4000000;
      if (rb.un && $urandom_range(0, 1) == 1) rb.mant = 28'd0;
      present(rb, model(rb));
      acc = 1'b0;
      for (int n = 0; n < 40 && !acc; n++) begin
        i_ready = ($urandom_range(0, 3) != 0);
        tick(acc, hs);
      end
      if (!acc) checkOutput("rand_accept_timeout", 32'd0, 32'd1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
